beam_scan_sequencer: RTL and testbench

BEAM_SCAN_SEQUENCER -- requirements
Module: beam_scan_sequencer

---
 rtl/beam_scan_sequencer.sv | 170 +++++++++++++++++
 tb/tb_beam_scan_sequencer.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/beam_scan_sequencer.sv
// beam_scan_sequencer: steps a beam through angle_count scan lines and,
// per line, relays calculator terms to a valid/ready downstream sink.
// Ports: clk, rst (sync, active-high); scan_start, r_0, angle_start,
//   angle_step, angle_count -> busy, done, err; calc_* calculator handshake
//   (calc_initiate/calc_ack out, calc_term_*/calc_last/calc_ready in);
//   term_valid/term_ready/term_pos/term_neg downstream; elem_idx, line_idx.
// Optional macro SEQ_WATCHDOG_EN: abort a scan after 255 idle WAIT_TERM
//   cycles with err set and a done pulse.
module beam_scan_sequencer #(
   parameter int ANGLE_DW     = 8,
   parameter int DW_TERM      = 25,
   parameter int NUM_ELEMENTS = 33
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                scan_start,
   input  logic [7:0]          r_0,
   input  logic [ANGLE_DW-1:0] angle_start,
   input  logic [ANGLE_DW-1:0] angle_step,
   input  logic [7:0]          angle_count,
   output logic                busy,
   output logic                done,
   output logic                err,
   output logic                calc_initiate,
   output logic                calc_ack,
   output logic [7:0]          calc_r_0,
   output logic [ANGLE_DW-1:0] calc_angle,
   input  logic [DW_TERM-1:0]  calc_term_pos,
   input  logic [DW_TERM-1:0]  calc_term_neg,
   input  logic                calc_last,
   input  logic                calc_ready,
   output logic                term_valid,
   input  logic                term_ready,
   output logic [DW_TERM-1:0]  term_pos,
   output logic [DW_TERM-1:0]  term_neg,
   output logic [5:0]          elem_idx,
   output logic [7:0]          line_idx
);

   typedef enum logic [2:0] {
      IDLE, INIT, WAIT_TERM, FWD, ACK, GAP, NEXT
   } state_t;

   localparam logic [5:0] ELEM_MAX = 6'(NUM_ELEMENTS - 1);

   state_t              state, state_nxt;
   logic [ANGLE_DW-1:0] step_q;
   logic [7:0]          count_q;
   logic                last_q;
   logic [7:0]          line_nxt;
   logic                cnt_zero;
   logic                wd_fire;

   assign line_nxt = line_idx + 8'd1;
   assign cnt_zero = (angle_count == 8'd0);

`ifdef SEQ_WATCHDOG_EN
   logic [7:0] wd_cnt;

   // Held at zero outside WAIT_TERM, so every entry starts from zero.
   always_ff @(posedge clk) begin
      if (rst || state != WAIT_TERM)
         wd_cnt <= 8'd0;
      else if (wd_cnt != 8'hFF)
         wd_cnt <= wd_cnt + 8'd1;
   end

   assign wd_fire = (state == WAIT_TERM) && !calc_ready
                    && (wd_cnt == 8'hFF);
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst)
         state <= IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt     = state;
      busy          = (state != IDLE);
      calc_initiate = (state == INIT);
      calc_ack      = (state == ACK);
      term_valid    = (state == FWD);
      unique case (state)
         IDLE:
            if (scan_start && !cnt_zero)
               state_nxt = INIT;
         INIT:
            state_nxt = WAIT_TERM;
         WAIT_TERM:
            if (wd_fire)
               state_nxt = IDLE;
            else if (calc_ready)
               state_nxt = FWD;
         FWD:
            if (term_ready)
               state_nxt = ACK;
         ACK:
            state_nxt = GAP;
         GAP:
            state_nxt = last_q ? NEXT : WAIT_TERM;
         NEXT:
            state_nxt = (line_nxt == count_q) ? IDLE : INIT;
         default:
            state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         done       <= 1'b0;
         err        <= 1'b0;
         calc_r_0   <= '0;
         calc_angle <= '0;
         step_q     <= '0;
         count_q    <= '0;
         term_pos   <= '0;
         term_neg   <= '0;
         last_q     <= 1'b0;
         elem_idx   <= '0;
         line_idx   <= '0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE:
               if (scan_start) begin
                  calc_r_0   <= r_0;
                  calc_angle <= angle_start;
                  step_q     <= angle_step;
                  count_q    <= angle_count;
                  err        <= 1'b0;
                  line_idx   <= '0;
                  elem_idx   <= '0;
                  done       <= cnt_zero;
               end
            INIT:
               elem_idx <= '0;
            WAIT_TERM:
               if (wd_fire) begin
                  err  <= 1'b1;
                  done <= 1'b1;
               end else if (calc_ready) begin
                  term_pos <= calc_term_pos;
                  term_neg <= calc_term_neg;
                  last_q   <= calc_last;
                  // Early last, or more terms than elements.
                  if (calc_last && elem_idx != ELEM_MAX)
                     err <= 1'b1;
                  if (!calc_last && elem_idx == ELEM_MAX)
                     err <= 1'b1;
               end
            ACK:
               if (!last_q && elem_idx != ELEM_MAX)
                  elem_idx <= elem_idx + 6'd1;
            NEXT: begin
               line_idx <= line_nxt;
               if (line_nxt == count_q)
                  done <= 1'b1;
               else
                  calc_angle <= calc_angle + step_q;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_beam_scan_sequencer.sv
// tb_beam_scan_sequencer: randomized scoreboard bench for the beam
// scan sequencer with a behavioural term-calculator model.
module tb_beam_scan_sequencer;

   localparam int AW = 8;
   localparam int TW = 25;
   localparam int NE = 33;

   logic          clk = 1'b0;
   logic          rst;
   logic          scan_start;
   logic [7:0]    r_0;
   logic [AW-1:0] angle_start;
   logic [AW-1:0] angle_step;
   logic [7:0]    angle_count;
   logic          busy, done, err;
   logic          calc_initiate, calc_ack;
   logic [7:0]    calc_r_0;
   logic [AW-1:0] calc_angle;
   logic [TW-1:0] calc_term_pos, calc_term_neg;
   logic          calc_last, calc_ready;
   logic          term_valid, term_ready;
   logic [TW-1:0] term_pos, term_neg;
   logic [5:0]    elem_idx;
   logic [7:0]    line_idx;

   beam_scan_sequencer dut (
      .clk(clk), .rst(rst), .scan_start(scan_start), .r_0(r_0),
      .angle_start(angle_start), .angle_step(angle_step),
      .angle_count(angle_count), .busy(busy), .done(done), .err(err),
      .calc_initiate(calc_initiate), .calc_ack(calc_ack),
      .calc_r_0(calc_r_0), .calc_angle(calc_angle),
      .calc_term_pos(calc_term_pos), .calc_term_neg(calc_term_neg),
      .calc_last(calc_last), .calc_ready(calc_ready),
      .term_valid(term_valid), .term_ready(term_ready),
      .term_pos(term_pos), .term_neg(term_neg),
      .elem_idx(elem_idx), .line_idx(line_idx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int            line;
      int            elem;
      logic [TW-1:0] pos;
      logic [TW-1:0] neg;
   } exp_t;

   exp_t term_q[$];
   int   angle_q[$];
   int   r0_exp;
   int   line_len[256];
   int   n_chk = 0, n_fail = 0;
   int   hs_count = 0, init_count = 0, ack_count = 0;
   int   done_count = 0, stall_seen = 0;
   int   m_line, m_phase, m_k, m_delay;
   bit   m_mute;
   int   tr_mode, stall_n;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Calculator model: one term per request, next term after calc_ack.
   initial begin
      calc_ready = 0; calc_last = 0;
      calc_term_pos = '0; calc_term_neg = '0;
      m_phase = 0; m_k = 0; m_delay = 0;
      forever begin
         tick();
         if (rst) begin
            m_phase = 0;
            calc_ready = 0;
         end else if (calc_initiate) begin
            m_line++;
            m_k = 0;
            m_phase = m_mute ? 0 : 1;
            m_delay = $urandom_range(0, 2);
         end else begin
            case (m_phase)
               1: if (m_delay > 0) m_delay--;
                  else begin
                     calc_term_pos = TW'($urandom);
                     calc_term_neg = TW'($urandom);
                     calc_last = (m_k == line_len[m_line] - 1);
                     calc_ready = 1;
                     term_q.push_back('{m_line,
                        (m_k > NE - 1) ? NE - 1 : m_k,
                        calc_term_pos, calc_term_neg});
                     m_phase = 2;
                  end
               2: if (term_valid) begin
                     calc_ready = 0;
                     m_phase = 3;
                  end
               3: if (calc_ack) begin
                     m_k++;
                     m_phase = calc_last ? 0 : 1;
                     m_delay = $urandom_range(0, 2);
                  end
               default: ;
            endcase
         end
      end
   end

   // Downstream sink: always ready, random, or a 5-cycle stall at
   // line 0 element 7.
   initial begin
      term_ready = 0;
      forever begin
         tick();
         case (tr_mode)
            0: term_ready = 1;
            1: term_ready = ($urandom_range(0, 3) != 0);
            default:
               if (term_valid && line_idx == 0 && elem_idx == 7
                   && stall_n < 5) begin
                  term_ready = 0;
                  stall_n++;
               end else
                  term_ready = 1;
         endcase
      end
   end

   // Monitor / scoreboard.
   logic          pv, pr;
   logic [63:0]   pdata;
   logic [AW-1:0] held;
   bit            angle_held;
   exp_t          e;
   int            a;

   always @(negedge clk) begin
      if (rst) begin
         pv = 0;
         angle_held = 0;
      end else begin
         if (calc_initiate && calc_ack)
            chk("init_ack_overlap", 1, 0);
         if (calc_initiate) begin
            init_count++;
            if (angle_q.size() == 0)
               chk("unexpected_initiate", 1, 0);
            else begin
               a = angle_q.pop_front();
               chk("calc_angle", 64'(calc_angle), 64'(a));
               chk("calc_r_0", 64'(calc_r_0), 64'(r0_exp));
            end
            held = calc_angle;
            angle_held = 1;
         end else if (busy && angle_held)
            chk("angle_stable", 64'(calc_angle), 64'(held));
         if (calc_ack) ack_count++;
         if (done) done_count++;
         if (pv && !pr) begin
            chk("valid_held", 64'(term_valid), 1);
            chk("data_held",
                {term_pos, term_neg, elem_idx, line_idx}, pdata);
         end
         if (term_valid && term_ready) begin
            hs_count++;
            if (term_q.size() == 0)
               chk("unexpected_term", 1, 0);
            else begin
               e = term_q.pop_front();
               chk("term_data", {term_pos, term_neg}, {e.pos, e.neg});
               chk("term_idx", {elem_idx, line_idx},
                   {6'(e.elem), 8'(e.line)});
            end
         end
         if (term_valid && !term_ready && line_idx == 0
             && elem_idx == 7)
            stall_seen++;
         pv = term_valid;
         pr = term_ready;
         pdata = {term_pos, term_neg, elem_idx, line_idx};
      end
   end

   task automatic start_pulse(input int r0, input int st, input int sp,
                              input int cnt);
      for (int l = 0; l < cnt; l++)
         angle_q.push_back((st + l * sp) % (1 << AW));
      r0_exp = r0;
      m_line = -1;
      r_0 = 8'(r0);
      angle_start = AW'(st);
      angle_step = AW'(sp);
      angle_count = 8'(cnt);
      scan_start = 1;
      tick();
      scan_start = 0;
   endtask

   task automatic run_scan(input int r0, input int st, input int sp,
                           input int cnt, input int mode,
                           input bit exp_err);
      int hs0, tot, cyc, d0, i0;
      tr_mode = mode;
      stall_n = 0;
      tot = 0;
      for (int l = 0; l < cnt; l++) tot += line_len[l];
      hs0 = hs_count;
      i0 = init_count;
      start_pulse(r0, st, sp, cnt);
      d0 = done_count;
      @(negedge clk);
      chk("err_cleared", 64'(err), 0);
      if (cnt == 0) begin
         chk("zero_done", 64'(done), 1);
         chk("zero_busy", 64'(busy), 0);
         @(negedge clk);
         chk("zero_done_pulse", 64'(done), 0);
         chk("zero_no_init", 64'(init_count), 64'(i0));
      end else begin
         chk("busy_after_start", 64'(busy), 1);
         cyc = 0;
         while (!done && cyc < 20000) begin
            @(negedge clk);
            cyc++;
         end
         chk("done_timeout", 64'(done), 1);
         chk("busy_at_done", 64'(busy), 0);
         chk("err_final", 64'(err), 64'(exp_err));
         chk("handshakes", 64'(hs_count - hs0), 64'(tot));
         chk("lines", 64'(init_count - i0), 64'(cnt));
         chk("queues_empty", 64'(angle_q.size() + term_q.size()), 0);
         @(negedge clk);
         chk("done_single", 64'(done), 0);
         chk("one_done", 64'(done_count - d0), 1);
      end
   endtask

   task automatic do_reset();
      rst = 1;
      tick();
      @(negedge clk);
      chk("rst_ctrl", {busy, done, err, calc_initiate, calc_ack,
                       term_valid}, 0);
      chk("rst_idx", {elem_idx, line_idx}, 0);
      chk("rst_calc", {calc_r_0, calc_angle}, 0);
      chk("rst_term", {term_pos, term_neg}, 0);
      tick();
      rst = 0;
      angle_q.delete();
      term_q.delete();
   endtask

   initial begin
      int cnt, cyc, hs0, i0, k0, d0;
      bit ee;
      rst = 1; scan_start = 0; r_0 = 0;
      angle_start = 0; angle_step = 0; angle_count = 0;
      tr_mode = 0; stall_n = 0; m_mute = 0; m_line = -1;
      for (int l = 0; l < 256; l++) line_len[l] = NE;
      repeat (3) tick();
      do_reset();

      run_scan(77, 10, 5, 3, 0, 0);
      run_scan(200, 250, 4, 3, 1, 0);
      run_scan(5, 0, 0, 0, 0, 0);
      stall_seen = 0;
      run_scan(9, 30, 7, 2, 2, 0);
      chk("stall_cycles", 64'(stall_seen), 5);

      line_len[1] = 21;
      line_len[2] = 35;
      run_scan(1, 100, 200, 4, 1, 1);
      line_len[1] = NE;
      line_len[2] = NE;
      run_scan(3, 17, 99, 2, 1, 0);

      for (int s = 0; s < 3; s++) begin
         cnt = $urandom_range(1, 3);
         ee = 0;
         for (int l = 0; l < cnt; l++) begin
            line_len[l] = ($urandom_range(0, 3) == 0) ?
                          $urandom_range(1, 36) : NE;
            if (line_len[l] != NE) ee = 1;
         end
         run_scan($urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 255), cnt, 1, ee);
      end
      for (int l = 0; l < 256; l++) line_len[l] = NE;

      // Reset in the middle of a scan.
      tr_mode = 1;
      hs0 = hs_count;
      start_pulse(8, 40, 3, 3);
      cyc = 0;
      while (hs_count - hs0 < 10 && cyc < 5000) begin
         @(negedge clk);
         cyc++;
      end
      chk("midscan_progress", 64'(hs_count - hs0 >= 10), 1);
      tick();
      do_reset();
      i0 = init_count;
      k0 = ack_count;
      repeat (30) @(negedge clk);
      chk("no_init_after_rst", 64'(init_count), 64'(i0));
      chk("no_ack_after_rst", 64'(ack_count), 64'(k0));
      chk("idle_after_rst", 64'(busy), 0);

      // Calculator never answers.
      m_mute = 1;
      d0 = done_count;
      start_pulse(2, 50, 1, 1);
      cyc = 0;
`ifdef SEQ_WATCHDOG_EN
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
      end
      chk("wd_done", 64'(done), 1);
      chk("wd_err", 64'(err), 1);
      chk("wd_idle", 64'(busy), 0);
      chk("wd_latency", 64'(cyc >= 250 && cyc <= 262), 1);
`else
      repeat (300) @(negedge clk);
      chk("hang_busy", 64'(busy), 1);
      chk("hang_no_done", 64'(done_count), 64'(d0));
`endif
      tick();
      do_reset();
      m_mute = 0;

      run_scan(11, 10, 5, 3, 1, 0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
